// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Shares the single register-file write port between the in-order pipeline
//   writeback (p_*) and a long-latency unit (ll_*) that returns results
//   through a valid/ready handshake. The pipeline always wins. LL results
//   fill idle write slots. A starvation counter asks the hazard unit for a
//   bubble (wb_stall) so an LL result cannot wait forever. A pending-destination
//   scoreboard (busy_mask) reports the sources that an in-flight LL op will
//   still write.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   p_we/p_rd/p_wdata   pipeline W-stage write request
//   ll_issue/ll_issue_rd LL op issued this cycle and its destination
//   ll_valid/ll_rd/ll_wdata, ll_ready   LL result handshake
//   rs1/rs2 -> rs1_busy/rs2_busy        D-stage scoreboard lookup
//   rf_we/rf_rd/rf_wdata                register-file write port
//   wb_stall            bubble request to the hazard unit
//   busy_mask           scoreboard contents (bit 0 always 0)
//
// Optional build macro WB_ARB_PERF_EN adds perf_conflict and perf_forced
// (32-bit wrapping event counters).
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_we,
    input  logic [4:0]            p_rd,
    input  logic [DATA_WIDTH-1:0] p_wdata,
    input  logic                  ll_issue,
    input  logic [4:0]            ll_issue_rd,
    input  logic                  ll_valid,
    input  logic [4:0]            ll_rd,
    input  logic [DATA_WIDTH-1:0] ll_wdata,
    output logic                  ll_ready,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_we,
    output logic [4:0]            rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_stall,
    output logic [31:0]           busy_mask
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]           perf_conflict,
    output logic [31:0]           perf_forced
`endif
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             p_write;
    logic             ll_ready_int;
    logic             ll_write;
    logic [31:0]      busy_mask_reg;
    logic [31:0]      busy_mask_next;
    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;

    // Writes to x0 do not occupy the port.
    assign p_write = p_we && (p_rd != 5'd0);

    // Results for x0 are swallowed immediately, even under a pipeline write.
    // Outputs are held inactive while rst is asserted.
    assign ll_ready_int = !rst && ll_valid && (!p_write || (ll_rd == 5'd0));
    assign ll_write     = ll_ready_int && (ll_rd != 5'd0);
    assign ll_ready     = ll_ready_int;

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = 5'd0;
        rf_wdata = '0;
        if (!rst && p_write) begin
            rf_we    = 1'b1;
            rf_rd    = p_rd;
            rf_wdata = p_wdata;
        end else if (ll_write) begin
            rf_we    = 1'b1;
            rf_rd    = ll_rd;
            rf_wdata = ll_wdata;
        end
    end

    // Scoreboard next state, one bit per architectural register. A new issue
    // to the same register as a retiring result wins: that op is still pending.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign busy_mask_next[gi] = 1'b0;
            end else begin : g_reg
                logic set_hit;
                logic clr_hit;
                assign set_hit = ll_issue && (ll_issue_rd == 5'(gi));
                assign clr_hit = ll_write && (ll_rd == 5'(gi));
                assign busy_mask_next[gi] = set_hit || (busy_mask_reg[gi] && !clr_hit);
            end
        end
    endgenerate

    // Counts consecutive cycles an offered LL result was refused.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!ll_valid || ll_ready_int) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != LIMIT) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask_reg  <= '0;
            starve_cnt_reg <= '0;
        end else begin
            busy_mask_reg  <= busy_mask_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    assign busy_mask = rst ? 32'd0 : busy_mask_reg;
    assign rs1_busy  = busy_mask[rs1];
    assign rs2_busy  = busy_mask[rs2];
    assign wb_stall  = !rst && (starve_cnt_reg == LIMIT);

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_conflict_reg;
    logic [31:0] perf_forced_reg;

    // perf_forced steps on the same edge that raises wb_stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_reg <= '0;
            perf_forced_reg   <= '0;
        end else begin
            if (ll_valid && !ll_ready_int) begin
                perf_conflict_reg <= perf_conflict_reg + 32'd1;
            end
            if ((starve_cnt_next == LIMIT) && (starve_cnt_reg != LIMIT)) begin
                perf_forced_reg <= perf_forced_reg + 32'd1;
            end
        end
    end

    assign perf_conflict = perf_conflict_reg;
    assign perf_forced   = perf_forced_reg;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_we;
    logic [4:0]    p_rd;
    logic [DW-1:0] p_wdata;
    logic          ll_issue;
    logic [4:0]    ll_issue_rd;
    logic          ll_valid;
    logic [4:0]    ll_rd;
    logic [DW-1:0] ll_wdata;
    logic          ll_ready;
    logic [4:0]    rs1, rs2;
    logic          rs1_busy, rs2_busy;
    logic          rf_we;
    logic [4:0]    rf_rd;
    logic [DW-1:0] rf_wdata;
    logic          wb_stall;
    logic [31:0]   busy_mask;
`ifdef WB_ARB_PERF_EN
    logic [31:0]   perf_conflict;
    logic [31:0]   perf_forced;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_rd(p_rd), .p_wdata(p_wdata),
        .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
        .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_wdata(ll_wdata), .ll_ready(ll_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .wb_stall(wb_stall), .busy_mask(busy_mask)
`ifdef WB_ARB_PERF_EN
        , .perf_conflict(perf_conflict), .perf_forced(perf_forced)
`endif
    );

    task automatic idle_inputs();
        p_we = 0; p_rd = 0; p_wdata = 0;
        ll_issue = 0; ll_issue_rd = 0;
        ll_valid = 0; ll_rd = 0; ll_wdata = 0;
        rs1 = 0; rs2 = 0;
    endtask

    // Advance one cycle; inputs are changed 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        next_cycle();
        next_cycle();
        tests_run++;
        if ({busy_mask, wb_stall, ll_ready, rf_we, rs1_busy, rs2_busy} !== 37'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy_mask, wb_stall, ll_ready, rf_we, rs1_busy, rs2_busy});
        rst = 0;
        #1;
        tests_run++;
        if (busy_mask !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mask_after: got %h expected 0", busy_mask);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_idle_write();
        pulse_reset();
        ll_issue = 1; ll_issue_rd = 5;
        next_cycle();
        ll_issue = 0;
        tests_run++;
        if (busy_mask !== 32'h20) begin
            tests_failed++;
            $display("FAIL idle_issue_mask: got %h expected %h", busy_mask, 32'h20);
        end
        ll_valid = 1; ll_rd = 5; ll_wdata = 32'h1234;
        #1;
        tests_run++;
        if ({ll_ready, rf_we, rf_rd, rf_wdata} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
            tests_failed++;
            $display("FAIL idle_write: got rdy=%b we=%b rd=%0d wd=%h expected rdy=1 we=1 rd=5 wd=1234",
                     ll_ready, rf_we, rf_rd, rf_wdata);
        end
        next_cycle();
        ll_valid = 0;
        #1;
        tests_run++;
        if (busy_mask[5] !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_clear: got %b expected 0", busy_mask[5]);
        end
        $display("[TB] test_idle_write done");
    endtask

    task automatic test_conflict();
        pulse_reset();
        p_we = 1; p_rd = 3; p_wdata = 32'hAA;
        ll_valid = 1; ll_rd = 7; ll_wdata = 32'h77;
        #1;
        tests_run++;
        if ({ll_ready, rf_we, rf_rd, rf_wdata} !== {1'b0, 1'b1, 5'd3, 32'hAA}) begin
            tests_failed++;
            $display("FAIL conflict_pipe: got rdy=%b we=%b rd=%0d wd=%h expected rdy=0 we=1 rd=3 wd=aa",
                     ll_ready, rf_we, rf_rd, rf_wdata);
        end
        next_cycle();
        p_we = 0;
        #1;
        tests_run++;
        if ({ll_ready, rf_we, rf_rd, rf_wdata} !== {1'b1, 1'b1, 5'd7, 32'h77}) begin
            tests_failed++;
            $display("FAIL conflict_ll: got rdy=%b we=%b rd=%0d wd=%h expected rdy=1 we=1 rd=7 wd=77",
                     ll_ready, rf_we, rf_rd, rf_wdata);
        end
        next_cycle();
        idle_inputs();
        #1;
        tests_run++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== '0) begin
            tests_failed++;
            $display("FAIL idle_port: got we=%b rd=%0d wd=%h expected 0/0/0", rf_we, rf_rd, rf_wdata);
        end
        $display("[TB] test_conflict done");
    endtask

    task automatic test_starvation();
        pulse_reset();
        ll_valid = 1; ll_rd = 12; ll_wdata = 32'hC0DE;
        for (int c = 1; c <= 12; c++) begin
            p_we = (c < 10); p_rd = 9; p_wdata = c;
            if (c > 10) ll_valid = 0;
            #1;
            tests_run++;
            if (wb_stall !== ((c == 9) || (c == 10))) begin
                tests_failed++;
                $display("FAIL starve_stall_c%0d: got %b expected %b", c, wb_stall, (c == 9) || (c == 10));
            end
            tests_run++;
            if (ll_ready !== (c == 10)) begin
                tests_failed++;
                $display("FAIL starve_ready_c%0d: got %b expected %b", c, ll_ready, c == 10);
            end
            next_cycle();
        end
        idle_inputs();
        $display("[TB] test_starvation done");
    endtask

    task automatic test_scoreboard();
        pulse_reset();
        ll_issue = 1; ll_issue_rd = 10;
        next_cycle();
        ll_issue = 0; rs1 = 10; rs2 = 11;
        #1;
        tests_run++;
        if ({busy_mask, rs1_busy, rs2_busy} !== {32'h400, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL sb_set: got mask=%h rs1b=%b rs2b=%b expected 400/1/0", busy_mask, rs1_busy, rs2_busy);
        end
        ll_valid = 1; ll_rd = 10; ll_wdata = 32'h5;
        ll_issue = 1; ll_issue_rd = 10;
        next_cycle();
        ll_valid = 0; ll_issue = 0;
        #1;
        tests_run++;
        if (busy_mask !== 32'h400 || rs1_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_set_wins: got mask=%h rs1b=%b expected 400/1", busy_mask, rs1_busy);
        end
        ll_valid = 1; ll_rd = 10;
        next_cycle();
        ll_valid = 0;
        #1;
        tests_run++;
        if (busy_mask !== 32'h0 || rs1_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_clear: got mask=%h rs1b=%b expected 0/0", busy_mask, rs1_busy);
        end
        idle_inputs();
        $display("[TB] test_scoreboard done");
    endtask

    task automatic test_zero_rd();
        pulse_reset();
        ll_issue = 1; ll_issue_rd = 0;
        next_cycle();
        ll_issue = 0;
        #1;
        tests_run++;
        if (busy_mask !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_issue: got %h expected 0", busy_mask);
        end
        p_we = 1; p_rd = 4; p_wdata = 32'h44;
        ll_valid = 1; ll_rd = 0; ll_wdata = 32'h99;
        #1;
        tests_run++;
        if ({ll_ready, rf_we, rf_rd, rf_wdata} !== {1'b1, 1'b1, 5'd4, 32'h44}) begin
            tests_failed++;
            $display("FAIL zero_result: got rdy=%b we=%b rd=%0d wd=%h expected rdy=1 we=1 rd=4 wd=44",
                     ll_ready, rf_we, rf_rd, rf_wdata);
        end
        next_cycle();
        idle_inputs();
        $display("[TB] test_zero_rd done");
    endtask

    task automatic test_reset_mid_op();
        pulse_reset();
        p_we = 1; p_rd = 1; p_wdata = 1;
        ll_valid = 1; ll_rd = 9; ll_wdata = 32'h9;
        for (int c = 0; c < 5; c++) begin
            ll_issue = (c < 2); ll_issue_rd = 5'(2 + c);
            next_cycle();
        end
        ll_issue = 0;
        #1;
        tests_run++;
        if (busy_mask !== 32'h0C || wb_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_setup: got mask=%h stall=%b expected 0c/0", busy_mask, wb_stall);
        end
        rst = 1;
        #1;
        tests_run++;
        if (ll_ready !== 1'b0 || rf_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_during_rst: got rdy=%b we=%b expected 0/0", ll_ready, rf_we);
        end
        next_cycle();
        rst = 0;
        idle_inputs();
        rs1 = 2; rs2 = 3;
        #1;
        tests_run++;
        if ({busy_mask, wb_stall, ll_ready, rf_we, rs1_busy, rs2_busy} !== 37'd0) begin
            tests_failed++;
            $display("FAIL mid_after_rst: got mask=%h stall=%b rdy=%b we=%b rs=%b%b expected all 0",
                     busy_mask, wb_stall, ll_ready, rf_we, rs1_busy, rs2_busy);
        end
`ifdef WB_ARB_PERF_EN
        tests_run++;
        if (perf_conflict !== 32'd0 || perf_forced !== 32'd0) begin
            tests_failed++;
            $display("FAIL mid_perf_clear: got %0d/%0d expected 0/0", perf_conflict, perf_forced);
        end
`endif
        // Seven denials after reset must not reach the limit if the count restarted.
        p_we = 1; p_rd = 1; ll_valid = 1; ll_rd = 9;
        for (int c = 0; c < 7; c++) next_cycle();
        #1;
        tests_run++;
        if (wb_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_starve_cleared: got %b expected 0", wb_stall);
        end
        idle_inputs();
        next_cycle();
        $display("[TB] test_reset_mid_op done");
    endtask

    task automatic test_random();
        logic [31:0] m_busy;
        int          m_streak;
        logic        m_prev_stall;
        logic        e_ready, e_we, e_stall;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [31:0] m_conf, m_forced;
        int          errs_here;
        pulse_reset();
        m_busy = 0; m_streak = 0; m_prev_stall = 0; m_conf = 0; m_forced = 0;
        errs_here = 0;
        for (int n = 0; n < 600; n++) begin
            e_stall = (m_streak >= LIMIT);
            if (e_stall && !m_prev_stall) m_forced++;
            // LL source: keeps an offer stable until taken.
            if (!ll_valid && ($urandom_range(1, 0) == 1)) begin
                ll_valid = 1;
                ll_rd    = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom);
                ll_wdata = $urandom;
            end
            // Hazard unit model: bubble the pipeline while a stall is requested.
            p_we    = e_stall ? 1'b0 : ($urandom_range(3, 0) != 0);
            p_rd    = 5'($urandom);
            p_wdata = $urandom;
            ll_issue    = ($urandom_range(2, 0) == 0);
            ll_issue_rd = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            #1;
            e_ready = ll_valid && (!(p_we && p_rd != 0) || ll_rd == 0);
            if (p_we && p_rd != 0) begin
                e_we = 1; e_rd = p_rd; e_wd = p_wdata;
            end else if (e_ready && ll_rd != 0) begin
                e_we = 1; e_rd = ll_rd; e_wd = ll_wdata;
            end else begin
                e_we = 0; e_rd = 0; e_wd = 0;
            end
            tests_run++;
            if ({ll_ready, rf_we, rf_rd, rf_wdata} !== {e_ready, e_we, e_rd, e_wd}) begin
                tests_failed++; errs_here++;
                if (errs_here < 10)
                    $display("FAIL rnd_port_n%0d: got rdy=%b we=%b rd=%0d wd=%h expected rdy=%b we=%b rd=%0d wd=%h",
                             n, ll_ready, rf_we, rf_rd, rf_wdata, e_ready, e_we, e_rd, e_wd);
            end
            tests_run++;
            if ({busy_mask, rs1_busy, rs2_busy, wb_stall} !== {m_busy, m_busy[rs1], m_busy[rs2], e_stall}) begin
                tests_failed++; errs_here++;
                if (errs_here < 10)
                    $display("FAIL rnd_state_n%0d: got mask=%h rs=%b%b stall=%b expected mask=%h rs=%b%b stall=%b",
                             n, busy_mask, rs1_busy, rs2_busy, wb_stall,
                             m_busy, m_busy[rs1], m_busy[rs2], e_stall);
            end
`ifdef WB_ARB_PERF_EN
            tests_run++;
            if (perf_conflict !== m_conf || perf_forced !== m_forced) begin
                tests_failed++; errs_here++;
                if (errs_here < 10)
                    $display("FAIL rnd_perf_n%0d: got %0d/%0d expected %0d/%0d",
                             n, perf_conflict, perf_forced, m_conf, m_forced);
            end
`endif
            // Reference update for the next cycle.
            if (ll_valid && !e_ready) m_conf++;
            if (e_ready && ll_rd != 0) m_busy[ll_rd] = 1'b0;
            if (ll_issue && ll_issue_rd != 0) m_busy[ll_issue_rd] = 1'b1;
            m_streak     = (ll_valid && !e_ready) ? m_streak + 1 : 0;
            m_prev_stall = e_stall;
            next_cycle();
            if (e_ready) ll_valid = 0;
        end
        idle_inputs();
        $display("[TB] test_random done, %0d mismatching cycles", errs_here);
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #1;
        test_reset();
        test_idle_write();
        test_conflict();
        test_starvation();
        test_scoreboard();
        test_zero_rd();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
